tenbit_serializer: RTL

- Downstream consumer of the 10-bit parallel register stage. Accepts its 10-bit output word through a valid/ready handshake.
- Shifts the word out on a single serial line, holding each bit for a programmable number of clocks.
- Drives a frame strobe while bits are on the line and a one-cycle done pulse when the frame ends.
- Feeds the lab's serial link/LED shifter.

---
 rtl/tenbit_pkg.sv | 15 +
 rtl/tenbit_serializer_bit_timer.sv | 30 +++
 rtl/tenbit_serializer.sv | 100 ++++++++++
 3 files changed

// File: rtl/tenbit_pkg.sv
// Shared definitions for the ten-bit serializer: default word width,
// controller state encoding and the level held on the line between frames.
package tenbit_pkg;

  localparam int WIDTH_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/tenbit_serializer_bit_timer.sv
// Modulo-CLKS_PER_BIT counter; bit_tick marks the last clock of the current bit.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bit_tick
);

  // Keep at least one counter bit so CLKS_PER_BIT=1 still elaborates.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign bit_tick = en && (count == TERMINAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= bit_tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/tenbit_serializer.sv
// Parallel-to-serial shifter: accepts a word on a valid/ready handshake and
// drives it bit by bit, each held CLKS_PER_BIT clocks, framed by frame/done.
module tenbit_serializer
  import tenbit_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEFAULT,
  parameter int CLKS_PER_BIT = 4,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         par_data,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic                     serial_out,
  output logic                     frame,
  output logic [$clog2(WIDTH)-1:0] bit_index,
  output logic                     done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_INDEX = IW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic             bit_tick;

  // Rotate rather than shift so the word's head bit is always at a fixed end.
  assign shift_next = MSB_FIRST ? {shift_reg[WIDTH-2:0], shift_reg[WIDTH-1]}
                                : {shift_reg[0], shift_reg[WIDTH-1:1]};

  function automatic logic head_bit(input logic [WIDTH-1:0] word);
    return MSB_FIRST ? word[WIDTH-1] : word[0];
  endfunction

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (state == SHIFT),
    .clr      (state != SHIFT),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      load_ready <= 1'b1;
      serial_out <= IDLE_LEVEL;
      frame      <= 1'b0;
      bit_index  <= '0;
      done       <= 1'b0;
      shift_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            state      <= SHIFT;
            load_ready <= 1'b0;
            frame      <= 1'b1;
            shift_reg  <= par_data;
            serial_out <= head_bit(par_data);
            bit_index  <= '0;
          end
        end
        SHIFT: begin
          if (bit_tick) begin
            if (bit_index == LAST_INDEX) begin
              state      <= DONE;
              frame      <= 1'b0;
              serial_out <= IDLE_LEVEL;
              done       <= 1'b1;
              bit_index  <= '0;
            end else begin
              shift_reg  <= shift_next;
              serial_out <= head_bit(shift_next);
              bit_index  <= bit_index + 1'b1;
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          done       <= 1'b0;
          load_ready <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          load_ready <= 1'b1;
          serial_out <= IDLE_LEVEL;
          frame      <= 1'b0;
          bit_index  <= '0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
